// File: rtl/cbi980_i2s_tx_if.sv
// cbi980_i2s_tx_if: sample-frame push stream and FIFO status between the register block and the I2S transmitter.
interface cbi980_i2s_tx_if #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8
);
    logic [2*SAMPLE_W-1:0]        sample_data;
    logic                         sample_valid;
    logic                         sample_ready;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;

    modport master (output sample_data, sample_valid, input sample_ready, fifo_level);
    modport slave  (input sample_data, sample_valid, output sample_ready, fifo_level);
endinterface

// File: rtl/cbi980_i2s_tx.sv
// cbi980_i2s_tx: frame FIFO plus Philips I2S serializer with start/run/stop sequencing and sticky underrun.
// Define CBI980_UNDERRUN_REPEAT_EN to replay the last frame on underrun instead of sending zeros.
module cbi980_i2s_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             aclk,
    input  logic             arstn,
    cbi980_i2s_tx_if.slave   smp,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] clkdiv_i,
    input  logic             underrun_clr_i,
    output logic             busy_o,
    output logic             underrun_o,
    output logic             bclk_o,
    output logic             lrclk_o,
    output logic             sdata_o
);
    localparam int FW = 2*SAMPLE_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW+1;
    localparam int CW = $clog2(FW);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state_q, state_d;

    logic [FW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [LW-1:0]    level_q, level_d;
    logic             rdy_q, push, pop, empty;
    logic [FW-1:0]    head, repl;

    logic [DIV_W-1:0] div_q, div_d, cdiv_q, cdiv_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d, bitcnt_nx;
    logic [FW-1:0]    sr_q, sr_d;
    logic             bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, ur_q, ur_d;
    logic             tc, fall, wrap, start, ur_set;

    assign push    = smp.sample_valid & rdy_q;
    assign empty   = level_q == '0;
    assign head    = mem[rp_q];
    assign level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge aclk or negedge arstn)
        if (!arstn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            wp_q    <= wp_q + AW'(push);
            rp_q    <= rp_q + AW'(pop);
            level_q <= level_d;
            rdy_q   <= level_d != LW'(FIFO_DEPTH);
        end

    always_ff @(posedge aclk)
        if (push) mem[wp_q] <= smp.sample_data;

`ifdef CBI980_UNDERRUN_REPEAT_EN
    logic [FW-1:0] last_q;
    always_ff @(posedge aclk or negedge arstn)
        if (!arstn) last_q <= '0;
        else if (pop) last_q <= head;
    assign repl = last_q;
`else
    assign repl = '0;
`endif

    assign tc        = div_q == cdiv_q;
    assign fall      = tc & bclk_q;
    assign wrap      = fall & (bitcnt_q == CW'(FW-1));
    assign bitcnt_nx = wrap ? '0 : bitcnt_q + CW'(1);
    assign start     = enable_i & ~empty;
    assign pop       = (state_q == IDLE & start) | (state_q == RUN & wrap & enable_i & ~empty);
    assign ur_set    = state_q == RUN & wrap & enable_i & empty;
    assign ur_d      = ur_set | (ur_q & ~underrun_clr_i);

    always_ff @(posedge aclk or negedge arstn)
        if (!arstn) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                  state_q == RUN  ? ((wrap & ~enable_i) ? STOP : RUN) :
                                    (fall ? IDLE : STOP);
    end

    // A frame wrap reloads the shift register instead of shifting; STOP only finishes the last BCLK.
    always_comb begin
        div_d    = div_q;
        cdiv_d   = cdiv_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        if (state_q == IDLE) begin
            div_d    = '0;
            bitcnt_d = '0;
            bclk_d   = 1'b0;
            lrclk_d  = 1'b0;
            sdata_d  = 1'b0;
            if (start) begin
                cdiv_d = clkdiv_i;
                sr_d   = head;
            end
        end else begin
            div_d  = tc ? '0 : div_q + DIV_W'(1);
            bclk_d = bclk_q ^ tc;
            if (fall && state_q == RUN) begin
                bitcnt_d = bitcnt_nx;
                sdata_d  = sr_q[FW-1];
                lrclk_d  = bitcnt_nx >= CW'(SAMPLE_W);
                sr_d     = (wrap && enable_i) ? (empty ? repl : head) : (sr_q << 1);
            end else if (fall) begin
                bitcnt_d = '0;
                lrclk_d  = 1'b0;
                sdata_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn)
        if (!arstn) begin
            div_q    <= '0;
            cdiv_q   <= '0;
            bitcnt_q <= '0;
            sr_q     <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            cdiv_q   <= cdiv_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            ur_q     <= ur_d;
        end

    assign smp.sample_ready = rdy_q;
    assign smp.fifo_level   = level_q;
    assign busy_o           = state_q != IDLE;
    assign underrun_o       = ur_q;
    assign bclk_o           = bclk_q;
    assign lrclk_o          = lrclk_q;
    assign sdata_o          = sdata_q;
endmodule

// File: doc/cbi980_i2s_tx.md
# cbi980_i2s_tx

I2S transmit scheduler for the CBI980 controller. It sits behind the AXI4-Lite register front-end and buffers stereo sample frames in a small FIFO. It generates BCLK/LRCLK from `aclk` through a programmable divider and shifts samples out in Philips I2S format: MSB first, one-BCLK delay after each LRCLK edge. It sequences start, run and graceful stop, and flags underruns to the register block.

## Interface
- `SAMPLE_W`, default 16: bits per channel slot; legal range 8..32.
- `DIV_W`, default 8: width of `clkdiv`.
- `FIFO_DEPTH`, default 8: frames buffered; must be a power of two, at least 2.

- `aclk`  in  1: clock.
- `arstn`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: run request from the control register.
- `clkdiv`  in  DIV_W: BCLK half-period minus one, in `aclk` cycles.
- `sample_data`  in  2*SAMPLE_W: frame; left channel in the upper half.
- `sample_valid`  in  1: frame push request.
- `sample_ready`  out  1: FIFO not full.
- `fifo_level`  out  log2(FIFO_DEPTH)+1: frames currently buffered.
- `busy`  out  1: state is not IDLE.
- `underrun`  out  1: sticky underrun flag.
- `underrun_clr`  in  1: clears `underrun`.
- `bclk`, `lrclk`, `sdata`  out  1 each: I2S outputs, all registered.

## Operation
- **FIFO**
  - A push occurs when `sample_valid & sample_ready`.
  - A pop occurs only on a frame load.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - There is no bypass: a frame pushed in the same cycle as a load attempt on an empty FIFO is not seen by that load.
- **State IDLE**
  - `bclk`, `lrclk` and `sdata` are held at 0; the divider and bit counter are cleared.
  - Go to RUN when `enable & fifo_level!=0`.
  - On entry to RUN, `clkdiv` is latched (later changes are ignored until the next start), one frame is popped into the shift register, and `bitcnt` is set to 0.
- **State RUN**
  - The divider counts 0..clkdiv. At terminal count `bclk` toggles.
  - Each falling BCLK edge:
    - `bitcnt` increments mod 2*SAMPLE_W.
    - `sdata` takes the shift-register MSB, then the register shifts left.
    - `lrclk` is set to `bitcnt_next >= SAMPLE_W`.
  - When `bitcnt` wraps from 2*SAMPLE_W-1 to 0 (frame wrap):
    - `sdata` still takes the old right-channel LSB.
    - If `enable`: load the next frame. If the FIFO is empty, load all-zero instead and set `underrun`.
    - If `!enable`: go to STOP; no pop.
- **State STOP**
  - BCLK runs for one more full period so the final LSB is clocked out.
  - At the next falling edge go to IDLE and set all outputs to 0.
  - `enable` reasserted during STOP has no effect until IDLE is reached.
- **Underrun flag**
  - `underrun` clears on `underrun_clr`.
  - Set has priority over clear in the same cycle.

## Timing
- Reset values:
  - `bclk`, `lrclk`, `sdata`, `busy`, `underrun` = 0.
  - `fifo_level` = 0.
  - `sample_ready` = 0 while `arstn` is low, and 1 in the first cycle after release.
- BCLK period is 2*(clkdiv+1) `aclk` cycles; `clkdiv`=0 gives `aclk`/2.
- The first rising BCLK edge comes clkdiv+1 cycles after IDLE→RUN.
- The MSB of the left channel appears on `sdata` at the first falling BCLK edge, i.e. 2*(clkdiv+1) cycles after start. `lrclk` is 0 from the start.
- `sdata` and `lrclk` change only together with a falling BCLK edge, so they are stable across the rising edge.
- Reset asserted mid-frame returns everything to reset values immediately; FIFO contents are discarded.

## Configuration
- `CBI980_UNDERRUN_REPEAT_EN`
  - Defined: on underrun the last loaded frame is reloaded instead of zeros, and `underrun` is still set. If no frame has been played since reset, zeros are loaded.
  - Undefined: zeros are loaded on underrun.

## Test plan
- Reset, push L=16'hA5F0 and R=16'h0F5A with `clkdiv`=1 and `enable`=1:
  - `sdata` is the bit stream of 32'hA5F00F5A, delayed one BCLK.
  - BCLK period is 4 cycles; `lrclk` rises at falling edge 16.
- Push one frame, keep `enable` high:
  - The second frame is all zeros and `underrun`=1.
  - With `CBI980_UNDERRUN_REPEAT_EN` defined, the A5F00F5A frame repeats instead.
- Fill 8 frames:
  - `sample_ready`=0 and `fifo_level`=8.
  - The first load drops `fifo_level` to 7 and `sample_ready` returns to 1.
- Deassert `enable` mid-frame:
  - The current frame completes, then one extra BCLK carries the R LSB.
  - Then IDLE: outputs are 0, `busy`=0, and the remaining FIFO frames are kept.
- Assert `arstn`=0 in the middle of the left slot:
  - All outputs go to 0 asynchronously and `fifo_level`=0.
  - `underrun_clr` together with a new underrun leaves the flag at 1.
